sram_controller: RTL

Sequencer for the external 16-bit asynchronous SRAM behind the data-cache controller. It accepts one 32-bit write or one 64-bit line-fill read at a time and splits it into 16-bit SRAM phases with a fixed number of wait states. It drives the SRAM control pins and reports completion with a one-cycle `ready` pulse, which is the cache controller's SRAM-ready input.

---
 rtl/sram_pkg.sv | 37 +++
 rtl/sram_phase_timer.sv | 48 ++++
 rtl/sram_controller.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sram_pkg: shared types, widths and address helpers for the SRAM sequencer  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned c_addr_base_default = 1024;
  localparam int          c_sram_aw           = 18;
  localparam int          c_sram_dw           = 16;
  localparam int          c_read_phases       = 4;
  localparam int          c_write_phases      = 2;

  // Line reads start on an 8-byte boundary, word writes on a 4-byte boundary.
  function automatic logic [c_sram_aw-1:0] read_base(input logic [31:0] address,
                                                     input logic [31:0] base);
    logic [31:0] off;
    off = address - base;
    return {off[18:3], 2'b00};
  endfunction

  function automatic logic [c_sram_aw-1:0] write_base(input logic [31:0] address,
                                                      input logic [31:0] base);
    logic [31:0] off;
    off = address - base;
    return {off[18:2], 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_phase_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sram_phase_timer: wait-state counter and phase counter for SRAM accesses   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sram_phase_timer #(
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       enable,
  input  logic [2:0] num_phases,
  output logic [3:0] wait_cnt,
  output logic [1:0] phase_cnt,
  output logic       last_cycle_of_phase,
  output logic       last_phase_done
);

  localparam logic [3:0] c_wait_last = 4'(WAIT_CYCLES - 1);

  logic [3:0] r_wait;
  logic [1:0] r_phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait  <= '0;
      r_phase <= '0;
    end else if (start) begin
      r_wait  <= '0;
      r_phase <= '0;
    end else if (enable) begin
      if (r_wait == c_wait_last) begin
        r_wait  <= '0;
        r_phase <= r_phase + 2'd1;
      end else begin
        r_wait  <= r_wait + 4'd1;
      end
    end
  end

  assign wait_cnt            = r_wait;
  assign phase_cnt           = r_phase;
  assign last_cycle_of_phase = enable && (r_wait == c_wait_last);
  assign last_phase_done     = last_cycle_of_phase && (r_phase == 2'(num_phases - 3'd1));

endmodule
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sram_controller: splits 64-bit reads / 32-bit writes into 16-bit SRAM phases |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sram_controller
  import sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 4,
  parameter int unsigned ADDR_BASE   = c_addr_base_default
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [63:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  // we_n must be high in the final cycle of a phase; it is set one cycle ahead.
  localparam logic [3:0] c_we_rise = 4'(WAIT_CYCLES - 2);

  state_t      r_state, w_state_next;
  logic [31:0] r_wdata;
  logic [63:0] r_read_data;
  logic        r_ready,  w_ready_next;
  logic [17:0] r_addr,   w_addr_next;
  logic [15:0] r_dq_out, w_dq_out_next;
  logic        r_dq_oe,  w_dq_oe_next;
  logic        r_ce_n,   w_ce_n_next;
  logic        r_oe_n,   w_oe_n_next;
  logic        r_we_n,   w_we_n_next;
  logic        r_bn,     w_bn_next;

  logic        w_start, w_enable;
  logic [2:0]  w_num_phases;
  logic [3:0]  w_wait_cnt;
  logic [1:0]  w_phase_cnt;
  logic        w_last_cycle, w_last_phase;

  assign w_start      = (r_state == ST_IDLE);
  assign w_enable     = (r_state == ST_READ) || (r_state == ST_WRITE);
  assign w_num_phases = (r_state == ST_WRITE) ? 3'(c_write_phases) : 3'(c_read_phases);

  sram_phase_timer #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_timer (
    .clk                 (clk),
    .rst                 (rst),
    .start               (w_start),
    .enable              (w_enable),
    .num_phases          (w_num_phases),
    .wait_cnt            (w_wait_cnt),
    .phase_cnt           (w_phase_cnt),
    .last_cycle_of_phase (w_last_cycle),
    .last_phase_done     (w_last_phase)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Pin values are computed for the coming cycle so every output is a flop.
  always_comb begin
    w_state_next  = r_state;
    w_ready_next  = 1'b0;
    w_addr_next   = '0;
    w_dq_out_next = '0;
    w_dq_oe_next  = 1'b0;
    w_ce_n_next   = 1'b1;
    w_oe_n_next   = 1'b1;
    w_we_n_next   = 1'b1;
    w_bn_next     = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (rd_en) begin
          w_state_next = ST_READ;
          w_addr_next  = read_base(address, 32'(ADDR_BASE));
          w_ce_n_next  = 1'b0;
          w_oe_n_next  = 1'b0;
          w_bn_next    = 1'b0;
        end else if (wr_en) begin
          w_state_next  = ST_WRITE;
          w_addr_next   = write_base(address, 32'(ADDR_BASE));
          w_dq_out_next = write_data[15:0];
          w_dq_oe_next  = 1'b1;
          w_ce_n_next   = 1'b0;
          w_we_n_next   = 1'b0;
          w_bn_next     = 1'b0;
        end
      end
      ST_READ: begin
        if (w_last_phase) begin
          w_state_next = ST_DONE;
          w_ready_next = 1'b1;
        end else begin
          w_addr_next = r_addr + {17'd0, w_last_cycle};
          w_ce_n_next = 1'b0;
          w_oe_n_next = 1'b0;
          w_bn_next   = 1'b0;
        end
      end
      ST_WRITE: begin
        if (w_last_phase) begin
          w_state_next = ST_DONE;
          w_ready_next = 1'b1;
        end else begin
          w_addr_next   = r_addr + {17'd0, w_last_cycle};
          w_dq_out_next = w_last_cycle ? r_wdata[31:16] : r_dq_out;
          w_dq_oe_next  = 1'b1;
          w_ce_n_next   = 1'b0;
          w_we_n_next   = (w_wait_cnt == c_we_rise) && !w_last_cycle;
          w_bn_next     = 1'b0;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdata     <= '0;
      r_read_data <= '0;
      r_ready     <= 1'b0;
      r_addr      <= '0;
      r_dq_out    <= '0;
      r_dq_oe     <= 1'b0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_bn        <= 1'b1;
    end else begin
      r_ready  <= w_ready_next;
      r_addr   <= w_addr_next;
      r_dq_out <= w_dq_out_next;
      r_dq_oe  <= w_dq_oe_next;
      r_ce_n   <= w_ce_n_next;
      r_oe_n   <= w_oe_n_next;
      r_we_n   <= w_we_n_next;
      r_bn     <= w_bn_next;
      if ((r_state == ST_IDLE) && !rd_en && wr_en)
        r_wdata <= write_data;
      if ((r_state == ST_READ) && w_last_cycle)
        r_read_data[{w_phase_cnt, 4'b0000} +: 16] <= sram_dq_in;
    end
  end

  assign read_data   = r_read_data;
  assign ready       = r_ready;
  assign sram_addr   = r_addr;
  assign sram_dq_out = r_dq_out;
  assign sram_dq_oe  = r_dq_oe;
  assign sram_ce_n   = r_ce_n;
  assign sram_oe_n   = r_oe_n;
  assign sram_we_n   = r_we_n;
  assign sram_ub_n   = r_bn;
  assign sram_lb_n   = r_bn;

endmodule
`default_nettype wire
